array_0_2_ctrl: RTL and testbench

ARRAY_0_2_CTRL -- requirements
Module: array_0_2_ctrl

---
 rtl/array_0_2_ctrl.sv | 132 +++++++++++++
 tb/tb_array_0_2_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/array_0_2_ctrl.sv
// Controller in front of a single-port RAM.
// After reset, every RAM word is cleared, one word per cycle. The controller
// then serves read and write requests. Read data is returned through a
// 2-entry response FIFO, oldest response first.
module array_0_2_ctrl #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 15,
  parameter int DEPTH  = 4096
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              init_done,
  output logic [ADDR_W-1:0] RW0_addr,
  output logic              RW0_en,
  output logic              RW0_wmode,
  output logic [DATA_W-1:0] RW0_wdata,
  input  logic [DATA_W-1:0] RW0_rdata
);

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [1:0]        count_q, count_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic              inflight_q, inflight_d;
  logic [DATA_W-1:0] fifo_q [2];

  logic       run;
  logic       pop;
  logic       push;
  logic       accept;
  logic       rd_accept;
  logic [2:0] credit;

  assign run        = (state_q == ST_RUN);
  assign init_done  = run;
  assign resp_valid = run && (count_q != 2'd0);
  assign resp_rdata = fifo_q[rd_ptr_q];
  assign pop        = resp_valid && resp_ready;
  // The RAM output becomes valid one cycle after the read is accepted.
  // The controller captures it into the FIFO in that cycle.
  assign push       = inflight_q;

  // A read is accepted only if, after this cycle's pop, fewer than two
  // responses are still owed. This keeps FIFO space for every read in
  // flight and still allows one read per cycle while the consumer drains.
  assign credit    = 3'(count_q) + 3'(inflight_q) - 3'(pop);
  assign req_ready = run && (req_write || (credit < 3'd2));
  assign accept    = req_valid && req_ready;
  assign rd_accept = accept && !req_write;

  // Next-state logic. The RAM port comes from the clear counter in INIT
  // and from the request bus in RUN.
  always_comb begin
    // NOTE: every output gets a default before the case statement. No path
    // leaves a signal unassigned, so no latch is inferred.
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    RW0_en     = 1'b0;
    RW0_wmode  = 1'b0;
    RW0_addr   = req_addr;
    RW0_wdata  = req_wdata;
    case (state_q)
      ST_INIT: begin
        RW0_en    = 1'b1;
        RW0_wmode = 1'b1;
        RW0_wdata = '0;
        RW0_addr  = clr_cnt_q;
        clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        if (clr_cnt_q == ADDR_W'(DEPTH - 1)) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        RW0_en    = accept;
        RW0_wmode = req_write;
      end
      default: state_d = ST_INIT;
    endcase
  end

  // Response FIFO bookkeeping. Pushing and popping in the same cycle leaves
  // the occupancy unchanged, even when the FIFO is full.
  always_comb begin
    count_d    = count_q + 2'(push) - 2'(pop);
    wr_ptr_d   = wr_ptr_q ^ push;
    rd_ptr_d   = rd_ptr_q ^ pop;
    inflight_d = rd_accept;
  end

  // Control state register. Reset discards every pending read and
  // buffered response, then restarts the clear from address 0.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments only. All
    // registers then see the values from before the clock edge.
    if (reset) begin
      state_q    <= ST_INIT;
      clr_cnt_q  <= '0;
      count_q    <= 2'd0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      inflight_q <= inflight_d;
    end
  end

  // FIFO storage: capture the RAM read data in the cycle after acceptance.
  always_ff @(posedge clock) begin
    // NOTE: the storage has no reset. count_q qualifies every entry, so a
    // stale word is never presented as a valid response.
    if (push) begin
      fifo_q[wr_ptr_q] <= RW0_rdata;
    end
  end

endmodule

// File: tb/tb_array_0_2_ctrl.sv
// Self-checking bench for array_0_2_ctrl.
// The bench uses a behavioural single-port RAM and a shadow memory as the
// reference model. Accepted reads push their expected data into a
// scoreboard queue. A separate monitor pops that queue and compares each
// delivered response.
module tb_array_0_2_ctrl;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 15;
  localparam int DEPTH  = 4096;

  logic              clock = 1'b0;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              init_done;
  logic [ADDR_W-1:0] RW0_addr;
  logic              RW0_en;
  logic              RW0_wmode;
  logic [DATA_W-1:0] RW0_wdata;
  logic [DATA_W-1:0] RW0_rdata;

  always #5 clock = ~clock;

  array_0_2_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .init_done  (init_done),
    .RW0_addr   (RW0_addr),
    .RW0_en     (RW0_en),
    .RW0_wmode  (RW0_wmode),
    .RW0_wdata  (RW0_wdata),
    .RW0_rdata  (RW0_rdata)
  );

  // Behavioural single-port RAM. Read data appears the cycle after a read
  // enable and holds until the next read.
  logic [DATA_W-1:0] ram [DEPTH];
  always @(posedge clock) begin
    if (RW0_en === 1'b1) begin
      if (RW0_wmode) ram[RW0_addr] <= RW0_wdata;
      else           RW0_rdata     <= ram[RW0_addr];
    end
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Reference state.
  logic [DATA_W-1:0] ref_mem [DEPTH];
  logic [DATA_W-1:0] exp_q [$];
  int                outstanding;
  logic              rr;
  logic              last_resp_valid;
  int                n_checks = 0;
  int                n_errors = 0;
  int                n_resp = 0;
  int                first_resp_cyc = -1;
  int                last_resp_cyc = -1;
  logic              hold_prev = 1'b0;
  logic [DATA_W-1:0] held_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare every delivered response with the scoreboard. It also
  // checks that a stalled response holds its data.
  initial forever begin
    @(negedge clock);
    if (reset === 1'b1) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev && resp_valid === 1'b1)
        check("resp_stable", resp_rdata, held_data);
      if (resp_valid === 1'b1 && resp_ready === 1'b1) begin
        check("resp_pending", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("resp_rdata", resp_rdata, exp_q.pop_front());
        n_resp++;
        if (first_resp_cyc < 0) first_resp_cyc = cyc;
        last_resp_cyc = cyc;
      end
      hold_prev = (resp_valid === 1'b1) && (resp_ready !== 1'b1);
      held_data = resp_rdata;
    end
  end

  // Drive one request cycle. Then check the ready rule: writes are always
  // accepted. A read is accepted while fewer than two reads remain
  // undelivered, counting a response that leaves in the same cycle. Also
  // check that the RAM port mirrors the request.
  task automatic cycle(input logic v, input logic w, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d, output logic acc);
    logic pop_now;
    logic exp_rdy;
    @(posedge clock);
    #1;
    req_valid  = v;
    req_write  = w;
    req_addr   = a;
    req_wdata  = d;
    resp_ready = rr;
    @(negedge clock);
    acc = v && (req_ready === 1'b1);
    last_resp_valid = resp_valid;
    if (init_done === 1'b1) begin
      pop_now = (resp_valid === 1'b1) && rr;
      exp_rdy = w || ((outstanding - int'(pop_now)) < 2);
      check("req_ready", req_ready, exp_rdy);
      check("rw0_en", RW0_en, acc);
      if (acc) begin
        check("rw0_wmode", RW0_wmode, w);
        check("rw0_addr", RW0_addr, a);
        if (w) check("rw0_wdata", RW0_wdata, d);
      end
      outstanding = outstanding + int'(acc && !w) - int'(pop_now);
    end
    if (acc) begin
      if (w) ref_mem[a] = d;
      else   exp_q.push_back(ref_mem[a]);
    end
  endtask

  task automatic idle(input int n);
    logic acc;
    repeat (n) cycle(1'b0, 1'b0, '0, '0, acc);
  endtask

  task automatic drain();
    logic acc;
    rr = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) cycle(1'b0, 1'b0, '0, '0, acc);
    check("drain_timeout", exp_q.size(), 0);
  endtask

  // Assert reset for two clock edges. Check the outputs after the first
  // edge. Clearing the reference model discards all buffered responses.
  task automatic do_reset();
    @(posedge clock);
    #1;
    reset = 1'b1;
    req_valid = 1'b0;
    rr = 1'b0;
    resp_ready = 1'b0;
    exp_q.delete();
    outstanding = 0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    @(posedge clock);
    @(negedge clock);
    check("rst_req_ready", req_ready, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_init_done", init_done, 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  // Clear sweep: after reset, the controller writes zero to addresses
  // 0..DEPTH-1 in consecutive cycles. init_done rises on the next cycle.
  task automatic init_sweep();
    int bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clock);
      if (i == 0) check("init_first_resp_valid", resp_valid, 0);
      if (!(RW0_en === 1'b1 && RW0_wmode === 1'b1 && RW0_wdata === '0 &&
            RW0_addr === ADDR_W'(i) && init_done === 1'b0 &&
            req_ready === 1'b0 && resp_valid === 1'b0))
        bad++;
    end
    check("init_sweep_bad_cycles", bad, 0);
    @(negedge clock);
    check("init_done", init_done, 1);
  endtask

  initial begin
    logic acc, acc0, acc1, acc2;
    int   nacc, resp_base, lat;
    logic v, w;
    logic [ADDR_W-1:0] a;

    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; resp_ready = 1'b0; rr = 1'b0; outstanding = 0;
    last_resp_valid = 1'b0;

    do_reset();
    init_sweep();

    // Write 0x1ABC to 0x005, then read it back in the next cycle.
    rr = 1'b1;
    cycle(1'b1, 1'b1, 12'h005, 15'h1ABC, acc); check("wr_accept", acc, 1);
    cycle(1'b1, 1'b0, 12'h005, '0, acc);       check("rd_accept", acc, 1);
    lat = 0;
    while (lat < 4 && last_resp_valid !== 1'b1) begin
      idle(1);
      lat++;
    end
    check("rd_resp_timeout", last_resp_valid, 1);
    drain();

    // Reading a word that was never written returns zero.
    cycle(1'b1, 1'b0, 12'h7FF, '0, acc); check("rd_unwritten_accept", acc, 1);
    drain();

    // Backpressure: two reads fit, the third one must wait.
    rr = 1'b0;
    cycle(1'b1, 1'b0, 12'h005, '0, acc0);
    cycle(1'b1, 1'b0, 12'h7FF, '0, acc1);
    cycle(1'b1, 1'b0, 12'h010, '0, acc2);
    check("bp_first", acc0, 1);
    check("bp_second", acc1, 1);
    check("bp_third_blocked", acc2, 0);
    cycle(1'b1, 1'b0, 12'h010, '0, acc); check("bp_still_blocked", acc, 0);
    idle(3);
    rr = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 3 && !acc; i++) cycle(1'b1, 1'b0, 12'h010, '0, acc);
    check("bp_third_accepted", acc, 1);
    drain();

    // Stream 100 reads with the consumer always ready.
    resp_base = n_resp;
    first_resp_cyc = -1;
    nacc = 0;
    for (int i = 0; i < 100; i++) begin
      cycle(1'b1, 1'b0, ADDR_W'($urandom_range(0, DEPTH - 1)), '0, acc);
      nacc += int'(acc);
    end
    check("stream_accepts", nacc, 100);
    drain();
    check("stream_responses", n_resp - resp_base, 100);
    check("stream_no_bubbles", last_resp_cyc - first_resp_cyc, 99);

    // Randomised mix of reads and writes under random backpressure.
    for (int i = 0; i < 600; i++) begin
      rr = ($urandom_range(0, 3) != 0);
      v  = ($urandom_range(0, 3) != 0);
      w  = $urandom_range(0, 1) == 1;
      a  = ($urandom_range(0, 1) == 1) ? ADDR_W'($urandom_range(0, 15)) : ADDR_W'($urandom);
      cycle(v, w, a, DATA_W'($urandom), acc);
    end
    drain();

    // Reset with two buffered responses. Both are dropped, and the clear
    // wipes the earlier writes.
    cycle(1'b1, 1'b1, 12'h005, 15'h2AAA, acc);
    cycle(1'b1, 1'b1, 12'h123, 15'h0F0F, acc);
    rr = 1'b0;
    cycle(1'b1, 1'b0, 12'h005, '0, acc);
    cycle(1'b1, 1'b0, 12'h123, '0, acc);
    idle(2);
    check("buffered_before_reset", last_resp_valid, 1);
    do_reset();
    init_sweep();
    rr = 1'b1;
    cycle(1'b1, 1'b0, 12'h005, '0, acc); check("post_reset_rd0", acc, 1);
    cycle(1'b1, 1'b0, 12'h123, '0, acc); check("post_reset_rd1", acc, 1);
    drain();
    idle(2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Watchdog: the run must always end, even if the DUT stalls.
  initial begin
    #2000000;
    n_errors++;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
